// File: rtl/ika3012_pkg.sv
// ika3012_pkg: shared types and word layout for the IKA2151 serial DAC stream receiver.
package ika3012_pkg;
  typedef enum logic {HUNT, LOCKED} state_t;
  typedef enum logic {CH_L, CH_R} ch_t;
  localparam int MANT_LSB = 3;
  localparam int MANT_W = 10;
  localparam int EXP_LSB = 13;
  localparam int EXP_W = 3;
  localparam int WORD_LEN = 16;
endpackage

// File: rtl/ika3012_fp_decode.sv
// ika3012_fp_decode: combinational {exponent, mantissa} floating-point word to 16-bit signed linear PCM.
module ika3012_fp_decode
  import ika3012_pkg::*;
(
  input  logic [EXP_W-1:0]  exp_val,
  input  logic [MANT_W-1:0] mant,
  output logic [15:0]       pcm
);
  logic [15:0] mant_sx;
  logic [EXP_W-1:0] shamt;
  assign mant_sx = {{(16-MANT_W){mant[MANT_W-1]}}, mant};
  assign shamt = exp_val - EXP_W'(1);
  assign pcm = (exp_val == '0) ? '0 : mant_sx << shamt;
endmodule

// File: rtl/ika3012_serial_rx.sv
// ika3012_serial_rx: deserializes IKA2151 SO/SH1/SH2 words and emits decoded stereo PCM pairs.
// Optional IKA3012_RAW_OUT_EN adds o_RAW_L/o_RAW_R carrying the accepted {E,M} fields.
module ika3012_serial_rx
  import ika3012_pkg::*;
(
  input  logic        i_EMUCLK,
  input  logic        i_RST_n,
  input  logic        i_PHI1_PCEN_n,
  input  logic        i_SO,
  input  logic        i_SH1,
  input  logic        i_SH2,
  output logic [15:0] o_L,
  output logic [15:0] o_R,
  output logic        o_SAMPLE_VALID,
  output logic        o_FRAME_ERR
`ifdef IKA3012_RAW_OUT_EN
  ,
  output logic [12:0] o_RAW_L,
  output logic [12:0] o_RAW_R
`endif
);
  localparam int FLD_W = EXP_LSB + EXP_W - MANT_LSB;
  state_t state, state_nx;
  ch_t last_ch, last_ch_nx, ch, cap_ch, dec_ch;
  // Bits [2:0] of a word are never used, so only the history feeding [15:3] is kept.
  logic [FLD_W-2:0] sr;
  logic [FLD_W-1:0] fld, cap;
  logic [4:0] cnt, nbits;
  logic prev1, prev2, en, fall1, fall2, bnd, accept, viol;
  logic acc_p, err_p, dec_v;
  logic [15:0] dec_pcm, dec_q, hold;
  assign en = ~i_PHI1_PCEN_n;
  assign fall1 = en & prev1 & ~i_SH1;
  assign fall2 = en & prev2 & ~i_SH2;
  assign bnd = fall1 | fall2;
  assign ch = fall2 ? CH_R : CH_L;
  assign nbits = (cnt == 5'd31) ? cnt : cnt + 5'd1;
  assign fld = {i_SO, sr};
  always_comb begin
    state_nx = state;
    last_ch_nx = last_ch;
    accept = 1'b0;
    viol = 1'b0;
    if (bnd && state == HUNT && !(fall1 && fall2)) begin
      state_nx = LOCKED;
      last_ch_nx = ch;
    end else if (bnd && state == LOCKED) begin
      if ((fall1 && fall2) || nbits != 5'(WORD_LEN) || ch == last_ch) begin
        viol = 1'b1;
        state_nx = HUNT;
      end else begin
        accept = 1'b1;
        last_ch_nx = ch;
      end
    end
  end
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state <= HUNT;
      last_ch <= CH_L;
    end else begin
      state <= state_nx;
      last_ch <= last_ch_nx;
    end
  end
  ika3012_fp_decode u_dec (
    .exp_val(cap[EXP_LSB-MANT_LSB +: EXP_W]),
    .mant   (cap[0 +: MANT_W]),
    .pcm    (dec_pcm)
  );
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      sr <= '0;
      prev1 <= 1'b0;
      prev2 <= 1'b0;
      cnt <= '0;
      acc_p <= 1'b0;
      err_p <= 1'b0;
      cap <= '0;
      cap_ch <= CH_L;
      dec_q <= '0;
      dec_v <= 1'b0;
      dec_ch <= CH_L;
      hold <= '0;
      o_L <= '0;
      o_R <= '0;
      o_SAMPLE_VALID <= 1'b0;
      o_FRAME_ERR <= 1'b0;
    end else begin
      if (en) begin
        sr <= fld[FLD_W-1:1];
        prev1 <= i_SH1;
        prev2 <= i_SH2;
        cnt <= bnd ? '0 : nbits;
      end
      acc_p <= accept;
      err_p <= viol;
      if (accept) begin
        cap <= fld;
        cap_ch <= ch;
      end
      dec_q <= dec_pcm;
      dec_v <= acc_p;
      dec_ch <= cap_ch;
      o_FRAME_ERR <= err_p;
      o_SAMPLE_VALID <= dec_v && dec_ch == CH_R;
      if (dec_v && dec_ch == CH_L) hold <= dec_q;
      if (dec_v && dec_ch == CH_R) begin
        o_L <= hold;
        o_R <= dec_q;
      end
    end
  end
`ifdef IKA3012_RAW_OUT_EN
  logic [12:0] raw_q, raw_hold;
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      raw_q <= '0;
      raw_hold <= '0;
      o_RAW_L <= '0;
      o_RAW_R <= '0;
    end else begin
      raw_q <= cap;
      if (dec_v && dec_ch == CH_L) raw_hold <= raw_q;
      if (dec_v && dec_ch == CH_R) begin
        o_RAW_L <= raw_hold;
        o_RAW_R <= raw_q;
      end
    end
  end
`endif
endmodule

// File: tb/tb_ika3012_serial_rx.sv
// tb_ika3012_serial_rx: directed stimulus against a word-level model of the serial receiver.
module tb_ika3012_serial_rx;
  logic i_EMUCLK = 1'b0;
  logic i_RST_n = 1'b0;
  logic i_PHI1_PCEN_n = 1'b1;
  logic i_SO = 1'b0;
  logic i_SH1 = 1'b1;
  logic i_SH2 = 1'b1;
  logic [15:0] o_L, o_R;
  logic o_SAMPLE_VALID, o_FRAME_ERR;
`ifdef IKA3012_RAW_OUT_EN
  logic [12:0] o_RAW_L, o_RAW_R;
`endif
  ika3012_serial_rx dut (
    .i_EMUCLK      (i_EMUCLK),
    .i_RST_n       (i_RST_n),
    .i_PHI1_PCEN_n (i_PHI1_PCEN_n),
    .i_SO          (i_SO),
    .i_SH1         (i_SH1),
    .i_SH2         (i_SH2),
    .o_L           (o_L),
    .o_R           (o_R),
    .o_SAMPLE_VALID(o_SAMPLE_VALID),
    .o_FRAME_ERR   (o_FRAME_ERR)
`ifdef IKA3012_RAW_OUT_EN
    ,
    .o_RAW_L       (o_RAW_L),
    .o_RAW_R       (o_RAW_R)
`endif
  );
  always #5 i_EMUCLK = ~i_EMUCLK;
  int cyc = 0;
  always @(posedge i_EMUCLK) cyc++;
  int n_vec = 0;
  int n_err = 0;
  bit q[$];
  int nb = 0;
  logic p1 = 1'b0, p2 = 1'b0, locked = 1'b0, last_r = 1'b0;
  logic [15:0] hold = '0, pend_L = '0, pend_R = '0, m_L = '0, m_R = '0;
  int pend_cyc = -10;
  int err_cyc = -10;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [15:0] dec(input logic [15:0] w);
    int e, m;
    e = int'(w[15:13]);
    m = int'(w[12:3]);
    if (m >= 512) m -= 1024;
    return (e == 0) ? 16'd0 : 16'(m * (2 ** (e - 1)));
  endfunction
  task automatic model_reset();
    q.delete();
    nb = 0;
    p1 = 1'b0;
    p2 = 1'b0;
    locked = 1'b0;
    hold = '0;
    pend_cyc = -10;
    err_cyc = -10;
  endtask
  task automatic model_step(input logic so, input logic s1, input logic s2, input int k);
    logic f1, f2;
    logic [15:0] w;
    q.push_back(so);
    if (q.size() > 16) void'(q.pop_front());
    nb = (nb < 31) ? nb + 1 : 31;
    f1 = p1 && !s1;
    f2 = p2 && !s2;
    p1 = s1;
    p2 = s2;
    if (f1 || f2) begin
      w = '0;
      for (int j = 0; j < q.size(); j++) w[16 - q.size() + j] = q[j];
      if (!locked) begin
        if (!(f1 && f2)) begin
          locked = 1'b1;
          last_r = f2;
        end
      end else if ((f1 && f2) || nb != 16 || f2 == last_r) begin
        locked = 1'b0;
        err_cyc = k + 1;
      end else begin
        last_r = f2;
        if (f2) begin
          pend_cyc = k + 2;
          pend_L = hold;
          pend_R = dec(w);
        end else hold = dec(w);
      end
      nb = 0;
    end
  endtask
  always @(posedge i_EMUCLK) begin
    #1;
    if (!i_RST_n) begin
      m_L = '0;
      m_R = '0;
    end else if (cyc == pend_cyc) begin
      m_L = pend_L;
      m_R = pend_R;
    end
    chk("o_L", o_L, m_L);
    chk("o_R", o_R, m_R);
    chk("valid", 16'(o_SAMPLE_VALID), 16'(i_RST_n && cyc == pend_cyc));
    chk("frame_err", 16'(o_FRAME_ERR), 16'(i_RST_n && cyc == err_cyc));
  end
  task automatic en_bit(input logic so, input logic s1, input logic s2);
    @(negedge i_EMUCLK);
    i_SO = so;
    i_SH1 = s1;
    i_SH2 = s2;
    i_PHI1_PCEN_n = 1'b0;
    model_step(so, s1, s2, cyc + 1);
    @(negedge i_EMUCLK);
    i_PHI1_PCEN_n = 1'b1;
  endtask
  // mode: 0 = SH1 falls on last bit, 1 = SH2, 2 = both, 3 = no strobe
  task automatic send(input logic [15:0] w, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      logic l;
      l = (i == n - 1);
      en_bit(w[i], !(l && (mode == 0 || mode == 2)), !(l && (mode == 1 || mode == 2)));
    end
  endtask
  task automatic settle();
    repeat (3) @(negedge i_EMUCLK);
  endtask
  initial begin
    model_reset();
    repeat (3) @(negedge i_EMUCLK);
    i_RST_n = 1'b1;
    send(16'h1234, 16, 1);
    send(16'h6800, 16, 0);
    send(16'hFFF8, 16, 1);
    settle();
    chk("lock_L", o_L, 16'h0400);
    chk("lock_R", o_R, 16'hFFC0);
    send(16'hEFF8, 16, 0);
    send(16'h0AA8, 16, 1);
    settle();
    chk("ext_L", o_L, 16'h7FC0);
    chk("ext_R", o_R, 16'h0000);
    send(16'h4321, 16, 0);
    send(16'h1111, 15, 1);
    @(posedge i_EMUCLK);
    #1;
    chk("short_err", 16'(o_FRAME_ERR), 16'd1);
    settle();
    chk("short_hold_L", o_L, 16'h7FC0);
    send(16'h2008, 16, 0);
    send(16'h3FF0, 16, 1);
    settle();
    chk("relock_L", o_L, 16'h00C8);
    chk("relock_R", o_R, 16'hFFFE);
    send(16'h2010, 16, 0);
    send(16'h2018, 16, 0);
    @(posedge i_EMUCLK);
    #1;
    chk("dup_err", 16'(o_FRAME_ERR), 16'd1);
    send(16'hABCD, 16, 2);
    @(posedge i_EMUCLK);
    #1;
    chk("both_hunt_err", 16'(o_FRAME_ERR), 16'd0);
    send(16'h6800, 16, 0);
    send(16'hFFF8, 16, 1);
    settle();
    chk("order_L", o_L, 16'h0002);
    send(16'h5555, 8, 3);
    @(negedge i_EMUCLK);
    i_RST_n = 1'b0;
    model_reset();
    #1;
    chk("rst_L", o_L, 16'h0000);
    chk("rst_R", o_R, 16'h0000);
    chk("rst_valid", 16'(o_SAMPLE_VALID), 16'd0);
    chk("rst_err", 16'(o_FRAME_ERR), 16'd0);
    repeat (3) @(negedge i_EMUCLK);
    i_RST_n = 1'b1;
    send(16'h6800, 16, 0);
    send(16'hFFF8, 16, 1);
    settle();
    chk("post_rst_L", o_L, 16'h0000);
    chk("post_rst_R", o_R, 16'hFFC0);
    send(16'h6800, 16, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge i_EMUCLK);
      i_SO = 1'($urandom_range(0, 1));
      i_SH1 = 1'($urandom_range(0, 1));
      i_SH2 = 1'($urandom_range(0, 1));
    end
    send(16'hFFF8, 16, 1);
    settle();
    chk("gate_L", o_L, 16'h0400);
    chk("gate_R", o_R, 16'hFFC0);
    repeat (5) @(negedge i_EMUCLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
